keypad_scan_ctrl: RTL and testbench
===================================

# keypad_scan_ctrl

Scan controller for the 4x4 matrix keypad feeding the seven-segment and game logic. It drives the keypad columns one at a time and samples the rows on a slow scan tick. It debounces a detected press by requiring consecutive identical samples, then reports one scan code per debounced press with a single-cycle valid pulse. Keypad input is shared through one scan/debounce resource in place of a per-button debouncer chain.

## Interface
- SCAN_DIV, 250000: clk cycles per scan tick (2.5 ms at 100 MHz).
- STABLE_CNT, 4: consecutive identical tick samples needed to accept a press or a release.
- REPEAT_DLY, 200: ticks held before the first auto-repeat; used only with KEYPAD_REPEAT_EN.
- REPEAT_RATE, 40: ticks between auto-repeats; used only with KEYPAD_REPEAT_EN.
- clk  input  1  system clock, 100 MHz.
- rst  input  1  reset; asynchronous and active-high.
- row_in  input  4  keypad rows, active-low (externally pulled up), asynchronous to clk.
- col_out  output  4  column drive, active-low one-hot.
- key_code  output  4  {row[1:0], col[1:0]} of the last accepted key.
- key_valid  output  1  one-clk pulse per accepted press (and per repeat, if enabled).
- key_held  output  1  high from press acceptance until release is debounced.

## Operation
- row_in passes through a 2-FF synchronizer. Synchronizer flops reset to 1.
- Tick generator: counter 0..SCAN_DIV-1; tick is high when count == SCAN_DIV-1, then the counter wraps to 0. Width is $clog2(SCAN_DIV).
- The column index increments mod 4: 0→1→2→3→0. col_out = ~(1 << col).
- States:
  - SCAN: on tick, if the synchronized rows are 4'b1111, advance the column. Otherwise latch the row pattern, set stable_cnt=1 and go to DEBOUNCE; the column is held.
  - DEBOUNCE: on tick, if the pattern equals the latched one, increment stable_cnt. At STABLE_CNT, go to PRESSED. If the pattern differs, return to SCAN and advance the column. If STABLE_CNT == 1, acceptance happens on the detecting tick itself.
  - PRESSED: entry sets key_code, pulses key_valid and sets key_held=1. On tick, rows 4'b1111 increments rel_cnt and any low row clears it. At STABLE_CNT, go to SCAN, clear key_held and advance the column.
- Multiple low rows in a column: the lowest-index low row is encoded in key_code. The full pattern is still used for the stability compare.
- Pattern changes in PRESSED (rollover, a second key) are ignored until release. A new key is never reported without a debounced release.
- stable_cnt and rel_cnt are $clog2(STABLE_CNT+1) bits and saturate (never wrap).
- Reset mid-operation clears everything immediately. No pulse is generated on reset release.

## Timing
- Reset values: col_out=4'b1110, key_code=4'h0, key_valid=0, key_held=0, state SCAN, all counters 0.
- Each column is driven for exactly SCAN_DIV clks before it is sampled. The 2-clk synchronizer delay lies inside this settle window.
- key_valid, key_code and key_held are registered. They change in the clk after the accepting tick. key_valid is high for exactly 1 clk.
- key_code is stable whenever key_valid=1 and holds until the next acceptance.
- Press-to-valid latency: STABLE_CNT ticks from the first low sample, plus 1 clk.
- Release: key_held falls 1 clk after the STABLE_CNT-th all-high tick. The column advances on that same tick.

## Configuration
- KEYPAD_REPEAT_EN defined: in PRESSED a repeat counter counts ticks.
  - The first extra key_valid pulse comes REPEAT_DLY ticks after acceptance, then one every REPEAT_RATE ticks while key_held=1.
  - Repeat pulses carry the same key_code.
  - A release in progress (rel_cnt > 0) does not suppress repeats. A completed release clears the repeat counter.
- Not defined: exactly one key_valid per press. The repeat counter and logic are absent, and REPEAT_DLY/REPEAT_RATE are ignored.

## Structure
- Package keypad_pkg: state enum (SCAN, DEBOUNCE, PRESSED), KEY_IDLE_ROWS = 4'b1111, col one-hot helper constant, and scan-code-to-digit mapping constants used downstream.
- One sub-module: scan_tick_gen (parameter SCAN_DIV; ports clk, rst, tick). This generalizes the existing slow clock-enable so the debouncer and this block share one style.

## Test plan
Run with SCAN_DIV=4 and STABLE_CNT=3 unless noted.
- Reset and idle: col_out=1110 and all outputs 0 during rst. After release, col_out steps 1110→1101→1011→0111→1110 every 4 clks, and key_valid never rises.
- Clean press, row 2 at column 1, held 40 clks: exactly one key_valid pulse with key_code=4'b1001, 3 ticks plus 1 clk after the first low sample. key_held=1 until 3 all-high ticks after release, then col_out advances to 1011.
- Bounce, row low for 2 ticks then high: no key_valid, key_held stays 0, scanning resumes from the next column.
- Rows 1 and 3 low together at column 2: key_code=4'b0110, single pulse.
- Reset mid-PRESSED: assert rst for 1 clk while key_held=1. Outputs clear asynchronously, col_out=1110, and no pulse follows reset release while the key is still held until it is debounced again.
- With KEYPAD_REPEAT_EN, REPEAT_DLY=5 and REPEAT_RATE=2: holding the key gives pulses at acceptance, +5 ticks, +7 ticks, +9 ticks, all with the same key_code. Pulses stop after the release is debounced.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 matrix keypad scanner.
// Optional feature macro honoured by keypad_scan_ctrl: KEYPAD_REPEAT_EN.
package keypad_pkg;

    // Scanner controller states
    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } scan_state_e;

    // Row pattern seen when no key in the driven column is pressed
    localparam logic [3:0] KEY_IDLE_ROWS = 4'b1111;

    // One-hot seed for the column drive, shifted by the column index
    localparam logic [3:0] COL_ONEHOT_BASE = 4'b0001;

    // Scan code {row, col} to keypad legend for the downstream display/game logic.
    // Nibble n holds the legend of scan code n:
    //   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: * 0 # D  (* -> E, # -> F)
    localparam logic [63:0] KEY_DIGIT_MAP = 64'hDF0E_C987_B654_A321;

    // Active-low one-hot column drive for a column index
    function automatic logic [3:0] colDrive(input logic [1:0] col);
        return ~(COL_ONEHOT_BASE << col);
    endfunction

    // Index of the lowest-numbered low (pressed) row in an active-low pattern
    function automatic logic [1:0] lowestLowRow(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd3;
        if (!rows[0]) begin
            idx = 2'd0;
        end else if (!rows[1]) begin
            idx = 2'd1;
        end else if (!rows[2]) begin
            idx = 2'd2;
        end
        return idx;
    endfunction

    // Keypad legend for a scan code
    function automatic logic [3:0] keyToDigit(input logic [3:0] code);
        return KEY_DIGIT_MAP[{code, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: free-running divider producing a one-clk tick every SCAN_DIV clks.
// Shared slow clock-enable style for the keypad scanner and the debouncers.
module scan_tick_gen #(
    parameter int SCAN_DIV = 250000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Count 0..SCAN_DIV-1 and wrap on the terminal count
    always_comb begin
        count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end

    // Divider register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = (count_q == LAST);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: column-scanning, debouncing 4x4 keypad controller.
// Reports one scan code per debounced press with a single-clk key_valid pulse.
// Define KEYPAD_REPEAT_EN to add auto-repeat pulses while a key stays held.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV    = 250000,
    parameter int STABLE_CNT  = 4
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_DLY  = 200,
    parameter int REPEAT_RATE = 40
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam logic [CW-1:0] LIM = CW'(STABLE_CNT);

    logic        tick;
    logic [3:0]  rowMeta_q;
    logic [3:0]  rowSync_q;

    scan_state_e state_q, state_d;
    logic [1:0]  col_q, col_d;
    logic [3:0]  latched_q, latched_d;
    logic [CW-1:0] stableCnt_q, stableCnt_d;
    logic [CW-1:0] relCnt_q, relCnt_d;
    logic [CW-1:0] stableInc, relInc;

    logic [3:0]  keyCode_q, keyCode_d;
    logic        keyValid_q, keyValid_d;
    logic        keyHeld_q, keyHeld_d;
    logic        accept, releaseDone;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int RW = $clog2(REP_MAX + 1);

    logic [RW-1:0] repCnt_q, repCnt_d;
    logic [RW-1:0] repInc, repTarget;
    logic          repFirst_q, repFirst_d;
`endif

    scan_tick_gen #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Saturating increments so the stability counters never wrap
    assign stableInc = (stableCnt_q == LIM) ? stableCnt_q : stableCnt_q + CW'(1);
    assign relInc    = (relCnt_q == LIM) ? relCnt_q : relCnt_q + CW'(1);

    // Two-flop synchronizer for the asynchronous rows; idles high like the pull-ups
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rowMeta_q <= KEY_IDLE_ROWS;
            rowSync_q <= KEY_IDLE_ROWS;
        end else begin
            rowMeta_q <= row_in;
            rowSync_q <= rowMeta_q;
        end
    end

    // State register plus the scan bookkeeping and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SCAN;
            col_q       <= 2'd0;
            latched_q   <= KEY_IDLE_ROWS;
            stableCnt_q <= '0;
            relCnt_q    <= '0;
            keyCode_q   <= 4'h0;
            keyValid_q  <= 1'b0;
            keyHeld_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            latched_q   <= latched_d;
            stableCnt_q <= stableCnt_d;
            relCnt_q    <= relCnt_d;
            keyCode_q   <= keyCode_d;
            keyValid_q  <= keyValid_d;
            keyHeld_q   <= keyHeld_d;
        end
    end

    // Next-state logic: scan, debounce a press, then wait for a debounced release
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        latched_d   = latched_q;
        stableCnt_d = stableCnt_q;
        relCnt_d    = relCnt_q;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (rowSync_q == KEY_IDLE_ROWS) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        latched_d   = rowSync_q;
                        stableCnt_d = CW'(1);
                        relCnt_d    = '0;
                        if (STABLE_CNT <= 1) begin
                            state_d = PRESSED;
                        end else begin
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (rowSync_q == latched_q) begin
                        stableCnt_d = stableInc;
                        if (stableInc >= LIM) begin
                            state_d  = PRESSED;
                            relCnt_d = '0;
                        end
                    end else begin
                        state_d     = SCAN;
                        col_d       = col_q + 2'd1;
                        stableCnt_d = '0;
                    end
                end
                PRESSED: begin
                    if (rowSync_q == KEY_IDLE_ROWS) begin
                        relCnt_d = relInc;
                        if (relInc >= LIM) begin
                            state_d     = SCAN;
                            col_d       = col_q + 2'd1;
                            relCnt_d    = '0;
                            stableCnt_d = '0;
                        end
                    end else begin
                        relCnt_d = '0;
                    end
                end
                default: begin
                    state_d     = SCAN;
                    stableCnt_d = '0;
                    relCnt_d    = '0;
                end
            endcase
        end
    end

    // Output logic: capture the code and pulse on acceptance, drop held on release
    always_comb begin
        accept      = (state_q != PRESSED) && (state_d == PRESSED);
        releaseDone = (state_q == PRESSED) && (state_d == SCAN);
        keyCode_d   = keyCode_q;
        keyValid_d  = 1'b0;
        keyHeld_d   = keyHeld_q;
        if (accept) begin
            keyCode_d  = {lowestLowRow(latched_d), col_q};
            keyValid_d = 1'b1;
            keyHeld_d  = 1'b1;
        end else if (releaseDone) begin
            keyHeld_d = 1'b0;
        end
`ifdef KEYPAD_REPEAT_EN
        repInc     = repCnt_q + RW'(1);
        repTarget  = repFirst_q ? RW'(REPEAT_RATE) : RW'(REPEAT_DLY);
        repCnt_d   = repCnt_q;
        repFirst_d = repFirst_q;
        if (accept || releaseDone) begin
            repCnt_d   = '0;
            repFirst_d = 1'b0;
        end else if ((state_q == PRESSED) && tick) begin
            if (repInc >= repTarget) begin
                keyValid_d = 1'b1;
                repCnt_d   = '0;
                repFirst_d = 1'b1;
            end else begin
                repCnt_d = repInc;
            end
        end
`endif
    end

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat tick counter, only meaningful while a key is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            repCnt_q   <= '0;
            repFirst_q <= 1'b0;
        end else begin
            repCnt_q   <= repCnt_d;
            repFirst_q <= repFirst_d;
        end
    end
`endif

    assign col_out   = colDrive(col_q);
    assign key_code  = keyCode_q;
    assign key_valid = keyValid_q;
    assign key_held  = keyHeld_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: directed bench for keypad_scan_ctrl with a 4x4 key matrix model.
// Build with KEYPAD_REPEAT_EN defined to also exercise auto-repeat.
`timescale 1ns/1ps
module tb_keypad_scan_ctrl;

    localparam int SCAN_DIV   = 4;
    localparam int STABLE_CNT = 3;
`ifdef KEYPAD_REPEAT_EN
    localparam int REPEAT_DLY  = 5;
    localparam int REPEAT_RATE = 2;
`endif

    typedef struct {
        logic [3:0] code;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keysDown = '0;

    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    exp_t expQ[$];

    keypad_scan_ctrl #(
        .SCAN_DIV   (SCAN_DIV),
        .STABLE_CNT (STABLE_CNT)
`ifdef KEYPAD_REPEAT_EN
        ,
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_RATE(REPEAT_RATE)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Key matrix: a pressed key pulls its row low while its column is driven low
    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keysDown[r*4+c] && !col_out[c]) begin
                    row_in[r] = 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic monitor();
        logic       expValid;
        logic [3:0] expCode;
        expValid = 1'b0;
        expCode  = 4'h0;
        if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
            expValid = 1'b1;
            expCode  = expQ[0].code;
            void'(expQ.pop_front());
        end
        checkOutput("key_valid", {31'b0, key_valid}, {31'b0, expValid});
        if (expValid) begin
            checkOutput("key_code_at_valid", {28'b0, key_code}, {28'b0, expCode});
        end
    endtask

    task automatic stepClk();
        @(posedge clk);
        if (rst) cyc = 0;
        else     cyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic stepTo(input int target);
        while (cyc < target) stepClk();
    endtask

    task automatic applyStimulus(input int row, input int col, input logic down);
        keysDown[row*4+col] = down;
    endtask

    task automatic expectPulse(input logic [3:0] code, input int atCyc);
        exp_t e;
        e.code = code;
        e.cyc  = atCyc;
        expQ.push_back(e);
    endtask

    task automatic resetDut();
        checkOutput("queue_drained", expQ.size(), 0);
        expQ.delete();
        keysDown = '0;
        rst = 1'b1;
        stepClk();
        stepClk();
        rst = 1'b0;
    endtask

    initial begin
        // Reset and idle scanning
        rst = 1'b1;
        stepClk();
        stepClk();
        checkOutput("rst_col_out", col_out, 4'b1110);
        checkOutput("rst_key_code", key_code, 4'h0);
        checkOutput("rst_key_valid", key_valid, 0);
        checkOutput("rst_key_held", key_held, 0);
        rst = 1'b0;
        stepTo(3);  checkOutput("idle_col_c3", col_out, 4'b1110);
        stepTo(4);  checkOutput("idle_col_c4", col_out, 4'b1101);
        stepTo(8);  checkOutput("idle_col_c8", col_out, 4'b1011);
        stepTo(12); checkOutput("idle_col_c12", col_out, 4'b0111);
        stepTo(16); checkOutput("idle_col_c16", col_out, 4'b1110);
        stepTo(20); checkOutput("idle_held", key_held, 0);

        // Clean press: row 2 at column 1
        resetDut();
        applyStimulus(2, 1, 1'b1);
        expectPulse(4'b1001, 16);
`ifdef KEYPAD_REPEAT_EN
        expectPulse(4'b1001, 36);
        expectPulse(4'b1001, 44);
        expectPulse(4'b1001, 52);
        expectPulse(4'b1001, 60);
`endif
        stepTo(15); checkOutput("press_held_before", key_held, 0);
        stepTo(16); checkOutput("press_held_accept", key_held, 1);
        stepTo(40); checkOutput("press_col_hold", col_out, 4'b1101);
        stepTo(52); applyStimulus(2, 1, 1'b0);
        stepTo(63); checkOutput("release_held_late", key_held, 1);
                    checkOutput("release_col_late", col_out, 4'b1101);
        stepTo(64); checkOutput("release_held_drop", key_held, 0);
                    checkOutput("release_col_adv", col_out, 4'b1011);
        stepTo(70); checkOutput("release_code_kept", key_code, 4'b1001);

        // Bounce: low for two ticks at column 0 then high
        resetDut();
        applyStimulus(3, 0, 1'b1);
        stepTo(8);  checkOutput("bounce_col_held", col_out, 4'b1110);
                    checkOutput("bounce_held_mid", key_held, 0);
        applyStimulus(3, 0, 1'b0);
        stepTo(12); checkOutput("bounce_col_next", col_out, 4'b1101);
        stepTo(16); checkOutput("bounce_col_scan", col_out, 4'b1011);
        stepTo(24); checkOutput("bounce_held_end", key_held, 0);
                    checkOutput("bounce_code", key_code, 4'h0);

        // Two rows low together at column 2
        resetDut();
        applyStimulus(1, 2, 1'b1);
        applyStimulus(3, 2, 1'b1);
        expectPulse(4'b0110, 20);
        stepTo(19); checkOutput("multi_held_before", key_held, 0);
        stepTo(20); checkOutput("multi_held_accept", key_held, 1);
        stepTo(24);
        applyStimulus(1, 2, 1'b0);
        applyStimulus(3, 2, 1'b0);
        stepTo(35); checkOutput("multi_held_late", key_held, 1);
                    checkOutput("multi_col_late", col_out, 4'b1011);
        stepTo(36); checkOutput("multi_held_drop", key_held, 0);
                    checkOutput("multi_col_adv", col_out, 4'b0111);
        stepTo(40); checkOutput("multi_code_kept", key_code, 4'b0110);

        // Reset while a key is held
        resetDut();
        applyStimulus(1, 0, 1'b1);
        expectPulse(4'b0100, 12);
        stepTo(20); checkOutput("midrst_held_pre", key_held, 1);
                    checkOutput("midrst_code_pre", key_code, 4'b0100);
        rst = 1'b1;
        #1;
        checkOutput("midrst_held_async", key_held, 0);
        checkOutput("midrst_code_async", key_code, 4'h0);
        checkOutput("midrst_valid_async", key_valid, 0);
        checkOutput("midrst_col_async", col_out, 4'b1110);
        stepClk();
        rst = 1'b0;
        expectPulse(4'b0100, 12);
        stepTo(11); checkOutput("midrst_held_redeb", key_held, 0);
                    checkOutput("midrst_code_redeb", key_code, 4'h0);
        stepTo(12); checkOutput("midrst_held_again", key_held, 1);
        stepTo(16); applyStimulus(1, 0, 1'b0);
        stepTo(27); checkOutput("midrst_held_late", key_held, 1);
        stepTo(28); checkOutput("midrst_held_drop", key_held, 0);
                    checkOutput("midrst_col_adv", col_out, 4'b1101);
        stepTo(36);

        checkOutput("final_queue_drained", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
